// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and its memory-side contract.
//
// Contents:
//   ADDR_W, WORD_W      address and data widths
//   MEM_COUNT_*         access-size encoding (NONE means no request on the bus)
//   MEM_CODE_*          memory response codes, including the unit-generated TIMEOUT
//   lsu_state_e         sequencer states
package load_store_unit_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned MEM_COUNT_W = 2;
  localparam int unsigned MEM_CODE_W  = 3;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;
  // Never produced by memory; raised by the unit when no response arrives.
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_TIMEOUT       = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/load_extender.sv
// Combinational size/sign extension of low-aligned load data.
//
// Ports:
//   count_i     access size (BYTE/HALF/WORD); other values pass data through
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   data_i      raw load data, low-aligned
//   data_o      extended result
module load_extender
  import load_store_unit_pkg::*;
(
  input  logic [MEM_COUNT_W-1:0] count_i,
  input  logic                   unsigned_i,
  input  logic [WORD_W-1:0]      data_i,
  output logic [WORD_W-1:0]      data_o
);

  logic fill_byte;
  logic fill_half;

  assign fill_byte = ~unsigned_i & data_i[7];
  assign fill_half = ~unsigned_i & data_i[15];

  always_comb begin
    data_o = data_i;
    case (count_i)
      MEM_COUNT_BYTE: data_o = {{(WORD_W - 8){fill_byte}}, data_i[7:0]};
      MEM_COUNT_HALF: data_o = {{(WORD_W - 16){fill_half}}, data_i[15:0]};
      default:        data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage sequencer: accepts one load/store per handshake, issues a single-cycle
// request to memory, captures and classifies the response, extends load data and holds
// the result until writeback takes it. One operation in flight at a time.
//
// Ports:
//   clk, aresetn                          clock, asynchronous active-low reset
//   i_valid/o_ready, i_store, i_addr,
//   i_wr_data, i_count, i_unsigned, i_rd  operation from execute
//   i_flush                               kill the in-flight result
//   o_req_*                               memory request bus (count NONE when idle)
//   i_res_rd_data, i_res_code             registered memory response
//   o_valid/i_ready, o_rd_data, o_rd,
//   o_wb_en, o_exc, o_exc_code            result to writeback
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_store,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [WORD_W-1:0]      i_wr_data,
  input  logic [MEM_COUNT_W-1:0] i_count,
  input  logic                   i_unsigned,
  input  logic [4:0]             i_rd,
  input  logic                   i_flush,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic                   o_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WORD_W-1:0]      o_rd_data,
  output logic [4:0]             o_rd,
  output logic                   o_wb_en,
  output logic                   o_exc,
  output logic [MEM_CODE_W-1:0]  o_exc_code
);

  // Timer value on the last permitted WAIT cycle.
  localparam logic [7:0] TimeoutLast = 8'(RESP_TIMEOUT - 1);

  lsu_state_e             state_q;
  logic [7:0]             timer_q;
  logic                   store_q;
  logic [MEM_COUNT_W-1:0] count_q;
  logic                   unsigned_q;
  logic                   flushed_q;

  logic [WORD_W-1:0]      ext_data;
  logic                   success;
  logic                   res_invalid;

  load_extender u_load_extender (
    .count_i    (count_q),
    .unsigned_i (unsigned_q),
    .data_i     (i_res_rd_data),
    .data_o     (ext_data)
  );

  assign o_ready     = (state_q == StIdle);
  assign res_invalid = (i_res_code == MEM_CODE_INVALID);
  // A response only counts as success when its direction matches the request.
  assign success     = (~store_q & (i_res_code == MEM_CODE_READ)) |
                       ( store_q & (i_res_code == MEM_CODE_WRITE));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      store_q       <= 1'b0;
      count_q       <= MEM_COUNT_NONE;
      unsigned_q    <= 1'b0;
      flushed_q     <= 1'b0;
      o_req_addr    <= '0;
      o_req_wr_data <= '0;
      o_req_wr_en   <= 1'b0;
      o_req_count   <= MEM_COUNT_NONE;
      o_valid       <= 1'b0;
      o_rd_data     <= '0;
      o_rd          <= '0;
      o_wb_en       <= 1'b0;
      o_exc         <= 1'b0;
      o_exc_code    <= MEM_CODE_INVALID;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid && !i_flush) begin
            store_q    <= i_store;
            count_q    <= i_count;
            unsigned_q <= i_unsigned;
            o_rd       <= i_rd;
            flushed_q  <= 1'b0;
            if (i_count == MEM_COUNT_NONE) begin
              // Nothing to send; report the bad size straight away.
              state_q    <= StDone;
              o_valid    <= 1'b1;
              o_exc      <= 1'b1;
              o_exc_code <= MEM_CODE_INVALID;
              o_rd_data  <= '0;
              o_wb_en    <= 1'b0;
            end else begin
              state_q       <= StReq;
              o_req_addr    <= i_addr;
              o_req_wr_data <= i_wr_data;
              o_req_wr_en   <= i_store;
              o_req_count   <= i_count;
            end
          end
        end

        StReq: begin
          o_req_count <= MEM_COUNT_NONE;
          o_req_wr_en <= 1'b0;
          timer_q     <= '0;
          state_q     <= StWait;
          if (i_flush) flushed_q <= 1'b1;
        end

        StWait: begin
          if (!res_invalid || timer_q == TimeoutLast) begin
            if (i_flush || flushed_q) begin
              // Bus transaction finished; the result is discarded.
              state_q   <= StIdle;
              flushed_q <= 1'b0;
            end else begin
              state_q <= StDone;
              o_valid <= 1'b1;
              if (res_invalid) begin
                o_exc      <= 1'b1;
                o_exc_code <= MEM_CODE_TIMEOUT;
                o_rd_data  <= '0;
                o_wb_en    <= 1'b0;
              end else begin
                o_exc      <= ~success;
                o_exc_code <= success ? MEM_CODE_INVALID : i_res_code;
                o_wb_en    <= success & ~store_q;
                o_rd_data  <= (success & ~store_q) ? ext_data : '0;
              end
            end
          end else begin
            timer_q <= timer_q + 8'd1;
            if (i_flush) flushed_q <= 1'b1;
          end
        end

        StDone: begin
          if (i_ready || i_flush) begin
            state_q    <= StIdle;
            o_valid    <= 1'b0;
            o_exc      <= 1'b0;
            o_exc_code <= MEM_CODE_INVALID;
            o_rd_data  <= '0;
            o_wb_en    <= 1'b0;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned RT        = 4;
  localparam int unsigned MEM_BYTES = 256;

  logic                   clk = 1'b0;
  logic                   aresetn;
  logic                   i_valid, o_ready, i_store, i_unsigned, i_flush, i_ready;
  logic [ADDR_W-1:0]      i_addr, o_req_addr;
  logic [WORD_W-1:0]      i_wr_data, o_req_wr_data, i_res_rd_data, o_rd_data;
  logic [MEM_COUNT_W-1:0] i_count, o_req_count;
  logic [4:0]             i_rd, o_rd;
  logic                   o_req_wr_en, o_valid, o_wb_en, o_exc;
  logic [MEM_CODE_W-1:0]  i_res_code, o_exc_code;

  always #5 clk = ~clk;

  load_store_unit #(.RESP_TIMEOUT(RT)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_store       (i_store),
    .i_addr        (i_addr),
    .i_wr_data     (i_wr_data),
    .i_count       (i_count),
    .i_unsigned    (i_unsigned),
    .i_rd          (i_rd),
    .i_flush       (i_flush),
    .o_req_addr    (o_req_addr),
    .o_req_wr_data (o_req_wr_data),
    .o_req_wr_en   (o_req_wr_en),
    .o_req_count   (o_req_count),
    .i_res_rd_data (i_res_rd_data),
    .i_res_code    (i_res_code),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_rd_data     (o_rd_data),
    .o_rd          (o_rd),
    .o_wb_en       (o_wb_en),
    .o_exc         (o_exc),
    .o_exc_code    (o_exc_code)
  );

  int n_checks = 0;
  int n_fails  = 0;

  function automatic int size_of(input logic [MEM_COUNT_W-1:0] c);
    case (c)
      MEM_COUNT_BYTE: return 1;
      MEM_COUNT_HALF: return 2;
      MEM_COUNT_WORD: return 4;
      default:        return 0;
    endcase
  endfunction

  // Memory-side rules: alignment first, then bounds.
  function automatic logic [MEM_CODE_W-1:0] access_code(input logic st,
      input logic [ADDR_W-1:0] addr, input logic [MEM_COUNT_W-1:0] c);
    int sz = size_of(c);
    if (sz == 0) return MEM_CODE_INVALID;
    if (addr % sz != 0) return MEM_CODE_MISALIGNED;
    if (longint'(addr) + sz > MEM_BYTES) return MEM_CODE_OUT_OF_BOUNDS;
    return st ? MEM_CODE_WRITE : MEM_CODE_READ;
  endfunction

  function automatic logic [7:0] pattern(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Stub memory_interface: samples a request and answers one cycle later with a
  // one-cycle response; unused upper read bits carry garbage.
  logic [7:0]            mem [MEM_BYTES];
  logic [7:0]            ref_mem [MEM_BYTES];
  logic                  mute, force_en;
  logic [MEM_CODE_W-1:0] force_code;
  logic [MEM_CODE_W-1:0] stub_code;
  logic [WORD_W-1:0]     stub_word;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = pattern(i);
      i_res_code    <= MEM_CODE_INVALID;
      i_res_rd_data <= '0;
    end else if (o_req_count != MEM_COUNT_NONE && !mute) begin
      stub_code = access_code(o_req_wr_en, o_req_addr, o_req_count);
      stub_word = $urandom;
      for (int i = 0; i < size_of(o_req_count); i++) begin
        if (stub_code == MEM_CODE_WRITE) mem[o_req_addr + i] = o_req_wr_data[8*i +: 8];
        if (stub_code == MEM_CODE_READ) stub_word[8*i +: 8] = mem[o_req_addr + i];
      end
      i_res_code    <= force_en ? force_code : stub_code;
      i_res_rd_data <= stub_word;
    end else begin
      i_res_code <= MEM_CODE_INVALID;
    end
  end

  task automatic ref_fill();
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = pattern(i);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Reference model: expected result of one operation from the architectural rules.
  task automatic model(input logic st, input logic [31:0] addr, input logic [31:0] wd,
      input logic [1:0] c, input logic uns, output logic e_exc, output logic [2:0] e_code,
      output logic [31:0] e_data, output logic e_wb, output int e_lat);
    int sz = size_of(c);
    logic [2:0] rx;
    longint v;
    e_exc = 1'b1; e_data = '0; e_wb = 1'b0; e_lat = 2; e_code = MEM_CODE_INVALID;
    if (c == MEM_COUNT_NONE) begin
      e_lat = 0;
    end else if (mute) begin
      e_code = MEM_CODE_TIMEOUT;
      e_lat  = 1 + RT;
    end else begin
      rx = force_en ? force_code : access_code(st, addr, c);
      if (rx == (st ? MEM_CODE_WRITE : MEM_CODE_READ)) begin
        e_exc = 1'b0;
        if (st) begin
          for (int i = 0; i < sz; i++) ref_mem[addr + i] = wd[8*i +: 8];
        end else begin
          v = 0;
          for (int i = 0; i < sz; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
          if (!uns && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v -= longint'(1) << (8 * sz);
          e_data = 32'(v);
          e_wb   = 1'b1;
        end
      end else begin
        e_code = rx;
      end
    end
  endtask

  task automatic issue(input logic st, input logic [31:0] addr, input logic [31:0] wd,
      input logic [1:0] c, input logic uns, input logic [4:0] rd);
    int guard = 0;
    while (!o_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_issue", o_ready, 1);
    i_valid = 1'b1; i_store = st; i_addr = addr; i_wr_data = wd;
    i_count = c; i_unsigned = uns; i_rd = rd;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Full operation: issue, bus check, bounded wait for o_valid, result check, handshake.
  task automatic run_op(input string tag, input logic st, input logic [31:0] addr,
      input logic [31:0] wd, input logic [1:0] c, input logic uns, output logic [31:0] got);
    logic e_exc, e_wb;
    logic [2:0] e_code;
    logic [31:0] e_data;
    int e_lat, lat;
    logic [4:0] rd = 5'($urandom);
    model(st, addr, wd, c, uns, e_exc, e_code, e_data, e_wb, e_lat);
    issue(st, addr, wd, c, uns, rd);
    check({tag, "_req_count"}, o_req_count, c);
    if (c != MEM_COUNT_NONE) begin
      check({tag, "_req_addr"}, o_req_addr, addr);
      check({tag, "_req_wr_en"}, o_req_wr_en, st);
      if (st) check({tag, "_req_wr_data"}, o_req_wr_data, wd);
    end
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_exc"}, o_exc, e_exc);
    if (e_exc) check({tag, "_exc_code"}, o_exc_code, e_code);
    check({tag, "_rd_data"}, o_rd_data, e_data);
    check({tag, "_wb_en"}, o_wb_en, e_wb);
    check({tag, "_rd"}, o_rd, rd);
    got = o_rd_data;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check({tag, "_valid_after_ack"}, o_valid, 0);
    check({tag, "_ready_after_ack"}, o_ready, 1);
  endtask

  initial begin
    logic [31:0] got;
    logic [1:0]  rc;
    aresetn = 1'b0; i_valid = 1'b0; i_store = 1'b0; i_addr = '0; i_wr_data = '0;
    i_count = MEM_COUNT_NONE; i_unsigned = 1'b0; i_rd = '0; i_flush = 1'b0; i_ready = 1'b0;
    mute = 1'b0; force_en = 1'b0; force_code = MEM_CODE_INVALID;
    ref_fill();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_req_count", o_req_count, MEM_COUNT_NONE);
    check("rst_exc", o_exc, 0);
    check("rst_rd_data", o_rd_data, 0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    run_op("sw", 1'b1, 32'h10, 32'hDEADBEEF, MEM_COUNT_WORD, 1'b0, got);
    run_op("lw", 1'b0, 32'h10, 32'h0, MEM_COUNT_WORD, 1'b0, got);
    check("lw_const", got, 32'hDEADBEEF);
    run_op("lb", 1'b0, 32'h13, 32'h0, MEM_COUNT_BYTE, 1'b0, got);
    check("lb_const", got, 32'hFFFFFFDE);
    run_op("lbu", 1'b0, 32'h13, 32'h0, MEM_COUNT_BYTE, 1'b1, got);
    check("lbu_const", got, 32'h000000DE);
    run_op("lh", 1'b0, 32'h12, 32'h0, MEM_COUNT_HALF, 1'b0, got);
    check("lh_const", got, 32'hFFFFDEAD);
    run_op("lhu", 1'b0, 32'h10, 32'h0, MEM_COUNT_HALF, 1'b1, got);
    check("lhu_const", got, 32'h0000BEEF);

    run_op("lw_mis", 1'b0, 32'h12, 32'h0, MEM_COUNT_WORD, 1'b0, got);
    run_op("sw_mis", 1'b1, 32'h12, 32'h12345678, MEM_COUNT_WORD, 1'b0, got);
    run_op("lw_after_mis", 1'b0, 32'h10, 32'h0, MEM_COUNT_WORD, 1'b0, got);
    check("lw_after_mis_const", got, 32'hDEADBEEF);
    run_op("sw_oob", 1'b1, MEM_BYTES, 32'hCAFEF00D, MEM_COUNT_WORD, 1'b0, got);
    check("sw_oob_data", got, 32'h0);

    // Writeback stalls for three cycles while execute keeps offering a new op.
    issue(1'b0, 32'h10, 32'h0, MEM_COUNT_WORD, 1'b0, 5'd9);
    repeat (2) begin @(posedge clk); #1; end
    check("bp_valid", o_valid, 1);
    i_valid = 1'b1; i_store = 1'b1; i_addr = 32'h40; i_count = MEM_COUNT_WORD;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", o_valid, 1);
      check("bp_hold_data", o_rd_data, 32'hDEADBEEF);
      check("bp_hold_rd", o_rd, 9);
      check("bp_ready_low", o_ready, 0);
      check("bp_no_req", o_req_count, MEM_COUNT_NONE);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("bp_released", o_ready, 1);

    // Flush while the store request is on the bus: store commits, no result.
    begin
      logic e_exc, e_wb; logic [2:0] e_code; logic [31:0] e_data; int e_lat;
      model(1'b1, 32'h20, 32'h55, MEM_COUNT_BYTE, 1'b0, e_exc, e_code, e_data, e_wb, e_lat);
    end
    issue(1'b1, 32'h20, 32'h55, MEM_COUNT_BYTE, 1'b0, 5'd3);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_req_valid1", o_valid, 0);
    @(posedge clk); #1;
    check("flush_req_valid2", o_valid, 0);
    check("flush_req_idle", o_ready, 1);
    repeat (3) begin @(posedge clk); #1; end
    check("flush_req_valid_late", o_valid, 0);
    run_op("lbu_flushed", 1'b0, 32'h20, 32'h0, MEM_COUNT_BYTE, 1'b1, got);
    check("lbu_flushed_const", got, 32'h55);

    // Flush while the result is waiting for writeback.
    issue(1'b0, 32'h10, 32'h0, MEM_COUNT_WORD, 1'b0, 5'd4);
    repeat (2) begin @(posedge clk); #1; end
    check("flush_done_valid", o_valid, 1);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_done_dropped", o_valid, 0);
    check("flush_done_idle", o_ready, 1);

    mute = 1'b1;
    run_op("timeout", 1'b0, 32'h10, 32'h0, MEM_COUNT_WORD, 1'b0, got);
    mute = 1'b0;
    run_op("none", 1'b1, 32'h10, 32'h0, MEM_COUNT_NONE, 1'b0, got);
    force_en = 1'b1; force_code = MEM_CODE_WRITE;
    run_op("mismatch", 1'b0, 32'h10, 32'h0, MEM_COUNT_WORD, 1'b0, got);
    force_en = 1'b0;

    // Reset while waiting on a silent memory.
    mute = 1'b1;
    issue(1'b0, 32'h10, 32'h0, MEM_COUNT_WORD, 1'b0, 5'd7);
    @(posedge clk); #1;
    aresetn = 1'b0;
    #2;
    check("rstw_ready", o_ready, 1);
    check("rstw_valid", o_valid, 0);
    check("rstw_req_count", o_req_count, MEM_COUNT_NONE);
    check("rstw_req_wr_en", o_req_wr_en, 0);
    check("rstw_exc", o_exc, 0);
    check("rstw_rd", o_rd, 0);
    aresetn = 1'b1;
    mute = 1'b0;
    ref_fill();
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      rc = ($urandom_range(0, 15) == 0) ? MEM_COUNT_NONE : 2'($urandom_range(1, 3));
      run_op("rand", 1'($urandom), 32'($urandom_range(0, MEM_BYTES + 15)), $urandom, rc,
             1'($urandom), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
